exec_controller: RTL and testbench

Execution controller for the Hack-style computer: it decides on which cycles the CPU and data memory advance. It sequences power-on reset, run/halt toggling and single-stepping from front-panel buttons, plus a PC breakpoint. It sits between the board buttons and the `CPU` / `memory` instances. Its `cpu_en` gates every state update in those instances: PC, A/D registers and RAM write.

---
 rtl/exec_controller.sv | 155 +++++++++++++++
 tb/tb_exec_controller.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exec_controller: power-on hold, run/halt, single-step and PC          |
// | breakpoint sequencing for the Hack CPU clock enable.  Rev 1.0         |
// +----------------------------------------------------------------------+
module exec_controller #(
  parameter int PC_W            = 15,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 2
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            run_btn,
  input  logic            step_btn,
  input  logic            bp_en,
  input  logic [PC_W-1:0] bp_addr,
  input  logic [PC_W-1:0] pc,
  output logic            cpu_en,
  output logic            cpu_reset,
  output logic            halted,
  output logic            bp_hit,
  output logic [15:0]     instr_count
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 2);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  // Index 0 is the run button, index 1 the step button.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      level_q, level_d;
  logic [1:0]      pulse_q, pulse_d;
  logic [DB_W-1:0] cnt_q [2];
  logic [DB_W-1:0] cnt_d [2];

  state_t          state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic            bp_hit_q, bp_hit_d;
  logic            skip_bp_q, skip_bp_d;
  logic [15:0]     count_q, count_d;
  logic            en_c;
  logic            run_p, step_p;
  logic            match;

  assign btn_raw = {step_btn, run_btn};
  assign run_p   = pulse_q[0];
  assign step_p  = pulse_q[1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_d[i] = level_q[i];
      pulse_d[i] = 1'b0;
      cnt_d[i]   = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
          pulse_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign match = bp_en && (pc == bp_addr) && !skip_bp_q;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    bp_hit_d  = bp_hit_q;
    skip_bp_d = skip_bp_q;
    en_c      = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_HALT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_HALT: begin
        if (run_p) begin
          state_d   = S_RUN;
          bp_hit_d  = 1'b0;
          skip_bp_d = 1'b1;
        end else if (step_p) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        en_c    = 1'b1;
        state_d = S_HALT;
      end
      S_RUN: begin
        // Breakpoint wins over a coincident run press so the stop is reported.
        if (match) begin
          state_d  = S_HALT;
          bp_hit_d = 1'b1;
        end else if (run_p) begin
          state_d = S_HALT;
        end else begin
          en_c      = 1'b1;
          skip_bp_d = 1'b0;
        end
      end
      default: state_d = S_HOLD;
    endcase
    count_d = (en_c && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      pulse_q   <= '0;
      cnt_q[0]  <= '0;
      cnt_q[1]  <= '0;
      state_q   <= S_HOLD;
      hold_q    <= '0;
      bp_hit_q  <= 1'b0;
      skip_bp_q <= 1'b0;
      count_q   <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      cnt_q[0]  <= cnt_d[0];
      cnt_q[1]  <= cnt_d[1];
      state_q   <= state_d;
      hold_q    <= hold_d;
      bp_hit_q  <= bp_hit_d;
      skip_bp_q <= skip_bp_d;
      count_q   <= count_d;
    end
  end

  assign cpu_en      = en_c;
  assign cpu_reset   = (state_q == S_HOLD);
  assign halted      = (state_q == S_HALT);
  assign bp_hit      = bp_hit_q;
  assign instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_exec_controller: directed checks of hold, step, run, breakpoint    |
// | and saturation behaviour with a small PC model.  Rev 1.0              |
// +----------------------------------------------------------------------+
module tb_exec_controller;

  localparam int PC_W = 15;

  logic            clk_in = 1'b0;
  logic            reset;
  logic            run_btn;
  logic            step_btn;
  logic            bp_en;
  logic [PC_W-1:0] bp_addr;
  logic [PC_W-1:0] pc_m;
  logic            cpu_en;
  logic            cpu_reset;
  logic            halted;
  logic            bp_hit;
  logic [15:0]     instr_count;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cycles = 0;
  int en_base;
  logic [PC_W-1:0] pc_exp;

  exec_controller #(
    .PC_W           (PC_W),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (2)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .run_btn    (run_btn),
    .step_btn   (step_btn),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc_m),
    .cpu_en     (cpu_en),
    .cpu_reset  (cpu_reset),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .instr_count(instr_count)
  );

  always #5 clk_in = ~clk_in;

  // CPU program counter: advances on each enabled edge.
  always @(posedge clk_in) begin
    if (cpu_reset) pc_m <= '0;
    else if (cpu_en) pc_m <= pc_m + 1'b1;
  end

  always @(negedge clk_in) begin
    if (cpu_en === 1'b1) en_cycles <= en_cycles + 1;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; run_btn = 1'b0; step_btn = 1'b0;
    bp_en = 1'b0; bp_addr = '0; pc_m = '0;

    // Reset and HOLD release
    tick(3);
    check_eq("rst_cpu_reset", 32'(cpu_reset), 1);
    check_eq("rst_cpu_en", 32'(cpu_en), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_bp_hit", 32'(bp_hit), 0);
    check_eq("rst_count", 32'(instr_count), 0);
    reset = 1'b0;
    tick(1);
    check_eq("hold1_cpu_reset", 32'(cpu_reset), 1);
    check_eq("hold1_halted", 32'(halted), 0);
    tick(1);
    check_eq("hold2_cpu_reset", 32'(cpu_reset), 1);
    check_eq("hold2_cpu_en", 32'(cpu_en), 0);
    tick(1);
    check_eq("halt_cpu_reset", 32'(cpu_reset), 0);
    check_eq("halt_halted", 32'(halted), 1);
    check_eq("halt_count", 32'(instr_count), 0);

    // Bouncy step press
    en_base = en_cycles;
    for (int k = 0; k < 3; k++) begin
      step_btn = 1'b1; tick(2);
      step_btn = 1'b0; tick(2);
    end
    step_btn = 1'b1; tick(10);
    step_btn = 1'b0; tick(12);
    check_eq("bounce_en_cycles", 32'(en_cycles - en_base), 1);
    check_eq("bounce_count", 32'(instr_count), 1);
    check_eq("bounce_halted", 32'(halted), 1);

    // Clean step: STEP cycle lands 7 edges after the press
    step_btn = 1'b1;
    tick(7);
    check_eq("step_cpu_en", 32'(cpu_en), 1);
    check_eq("step_not_halted", 32'(halted), 0);
    tick(1);
    check_eq("step_back_en", 32'(cpu_en), 0);
    check_eq("step_back_halted", 32'(halted), 1);
    check_eq("step_count", 32'(instr_count), 2);
    step_btn = 1'b0;
    tick(10);

    // Run for 100 cycles then halt
    en_base = en_cycles;
    run_btn = 1'b1;
    tick(7);
    check_eq("run_cpu_en", 32'(cpu_en), 1);
    check_eq("run_halted", 32'(halted), 0);
    tick(3);
    run_btn = 1'b0;
    tick(91);
    run_btn = 1'b1;
    tick(7);
    check_eq("stop_halted", 32'(halted), 1);
    check_eq("stop_cpu_en", 32'(cpu_en), 0);
    check_eq("stop_count", 32'(instr_count), 102);
    check_eq("stop_en_cycles", 32'(en_cycles - en_base), 100);
    run_btn = 1'b0;
    tick(10);

    // Breakpoint at PC 5 from a fresh reset
    reset = 1'b1; tick(2);
    reset = 1'b0; tick(3);
    check_eq("bp_pc_start", 32'(pc_m), 0);
    check_eq("bp_count_start", 32'(instr_count), 0);
    bp_en = 1'b1; bp_addr = 15'd5;
    run_btn = 1'b1; tick(10);
    run_btn = 1'b0; tick(10);
    check_eq("bp_halted", 32'(halted), 1);
    check_eq("bp_hit_set", 32'(bp_hit), 1);
    check_eq("bp_pc", 32'(pc_m), 5);
    check_eq("bp_count", 32'(instr_count), 5);
    run_btn = 1'b1;
    tick(7);
    check_eq("resume_bp_hit", 32'(bp_hit), 0);
    check_eq("resume_halted", 32'(halted), 0);
    check_eq("resume_cpu_en", 32'(cpu_en), 1);
    tick(1);
    check_eq("resume_pc", 32'(pc_m), 6);
    tick(2);
    run_btn = 1'b0;
    tick(10);
    check_eq("resume_running", 32'(halted), 0);

    // Run press coinciding with a breakpoint match
    pc_exp  = pc_m + 15'd6;
    bp_addr = pc_exp;
    run_btn = 1'b1;
    tick(7);
    check_eq("coinc_halted", 32'(halted), 1);
    check_eq("coinc_bp_hit", 32'(bp_hit), 1);
    check_eq("coinc_pc", 32'(pc_m), 32'(pc_exp));
    run_btn = 1'b0;
    bp_en   = 1'b0;
    tick(10);

    // Run and step pulses in the same HALT cycle
    run_btn = 1'b1; step_btn = 1'b1;
    tick(8);
    check_eq("both_halted", 32'(halted), 0);
    check_eq("both_cpu_en", 32'(cpu_en), 1);
    check_eq("both_bp_hit", 32'(bp_hit), 0);
    tick(2);
    check_eq("both_still_run", 32'(halted), 0);
    run_btn = 1'b0; step_btn = 1'b0;

    // Saturation, then reset mid-RUN
    tick(65600);
    check_eq("sat_count", 32'(instr_count), 32'hFFFF);
    tick(5);
    check_eq("sat_hold", 32'(instr_count), 32'hFFFF);
    check_eq("sat_running", 32'(cpu_en), 1);
    reset = 1'b1;
    tick(1);
    check_eq("midrst_cpu_en", 32'(cpu_en), 0);
    check_eq("midrst_cpu_reset", 32'(cpu_reset), 1);
    check_eq("midrst_count", 32'(instr_count), 0);
    check_eq("midrst_halted", 32'(halted), 0);
    reset = 1'b0;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
